// File: rtl/dff_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff_scan_pkg                                                         |
// | Shared types and limits for the scan-chain sequencing controller.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dff_scan_pkg;

   localparam int MAX_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/dff_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff_scan_ctrl_if                                                     |
// | Load and capture valid/ready handshakes between master and control.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dff_scan_ctrl_if
   import dff_scan_pkg::*;
#(
   parameter int WIDTH = 8
);
   logic             i_load_valid;
   logic             o_load_ready;
   logic [WIDTH-1:0] i_load_data;
   logic             o_cap_valid;
   logic             i_cap_ready;
   logic [WIDTH-1:0] o_cap_data;

   modport master (
      output i_load_valid,
      input  o_load_ready,
      output i_load_data,
      input  o_cap_valid,
      output i_cap_ready,
      input  o_cap_data
   );

   modport slave (
      input  i_load_valid,
      output o_load_ready,
      input  i_load_data,
      output o_cap_valid,
      input  i_cap_ready,
      output o_cap_data
   );
endinterface
`default_nettype wire

// File: rtl/dff_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff_chain                                                            |
// | Serial chain of WIDTH single-bit flops advancing on i_shift_en.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dff_chain
   import dff_scan_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_shift_en,
   input  logic i_D,
   output logic o_Q
);
   logic [WIDTH:0] w_tap;

   assign w_tap[0] = i_D;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic r_bit;

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            r_bit <= 1'b0;
         end else begin
            r_bit <= i_shift_en ? w_tap[i] : r_bit;
         end
      end

      assign w_tap[i+1] = r_bit;
   end

   assign o_Q = w_tap[WIDTH];
endmodule
`default_nettype wire

// File: rtl/dff_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff_scan_ctrl                                                        |
// | Shifts a parallel word into a flop chain LSB-first and captures the  |
// | word falling out of the tail for parallel readback.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dff_scan_ctrl
   import dff_scan_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   dff_scan_ctrl_if.slave bus,
   output logic          o_D,
   output logic          o_shift_en,
   input  logic          i_Q
);
   localparam int               c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   scan_state_t        r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_load_sr;
   logic [WIDTH-1:0]   r_cap_sr;
   logic               r_load_ready;
   logic               r_cap_valid;
   logic               r_shift_en;
   logic               r_d;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_load_sr    <= '0;
         r_cap_sr     <= '0;
         r_load_ready <= 1'b1;
         r_cap_valid  <= 1'b0;
         r_shift_en   <= 1'b0;
         r_d          <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_load_valid) begin
                  r_state      <= SHIFT;
                  r_load_sr    <= bus.i_load_data;
                  r_cnt        <= '0;
                  r_load_ready <= 1'b0;
                  r_shift_en   <= 1'b1;
                  r_d          <= bus.i_load_data[0];
               end
            end
            SHIFT: begin
               // Tail is sampled before this same edge advances the chain.
               r_load_sr <= r_load_sr >> 1;
               r_cap_sr  <= {i_Q, r_cap_sr[WIDTH-1:1]};
               if (r_cnt == c_last) begin
                  r_state     <= DONE;
                  r_shift_en  <= 1'b0;
                  r_d         <= 1'b0;
                  r_cap_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  r_d   <= r_load_sr[1];
               end
            end
            DONE: begin
               if (bus.i_cap_ready) begin
                  r_state      <= IDLE;
                  r_cap_valid  <= 1'b0;
                  r_load_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_load_ready = r_load_ready;
   assign bus.o_cap_valid  = r_cap_valid;
   assign bus.o_cap_data   = r_cap_sr;
   assign o_D              = r_d;
   assign o_shift_en       = r_shift_en;
endmodule
`default_nettype wire

// File: tb/tb_dff_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dff_scan_ctrl                                                     |
// | Directed bench: 8-bit and 2-bit controllers each driving a chain.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dff_scan_ctrl;
   logic clk;
   logic rst;
   logic d8, se8, q8;
   logic d2, se2, q2;
   int   checks = 0;
   int   errors = 0;

   dff_scan_ctrl_if #(.WIDTH(8)) if8 ();
   dff_scan_ctrl_if #(.WIDTH(2)) if2 ();

   dff_scan_ctrl #(.WIDTH(8)) u_ctrl8 (
      .i_clk(clk), .i_rst(rst), .bus(if8.slave),
      .o_D(d8), .o_shift_en(se8), .i_Q(q8)
   );
   dff_chain #(.WIDTH(8)) u_chain8 (
      .i_clk(clk), .i_rst(rst), .i_shift_en(se8), .i_D(d8), .o_Q(q8)
   );
   dff_scan_ctrl #(.WIDTH(2)) u_ctrl2 (
      .i_clk(clk), .i_rst(rst), .bus(if2.slave),
      .o_D(d2), .o_shift_en(se2), .i_Q(q2)
   );
   dff_chain #(.WIDTH(2)) u_chain2 (
      .i_clk(clk), .i_rst(rst), .i_shift_en(se2), .i_D(d2), .o_Q(q2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts at an IDLE negedge, ends at the first DONE negedge.
   task automatic exch8(input logic [7:0] w, input logic [7:0] exp_cap);
      chk("idle_ready", if8.o_load_ready, 1);
      if8.i_load_valid = 1'b1;
      if8.i_load_data  = w;
      @(negedge clk);
      if8.i_load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("shift_en", se8, 1);
         chk("d_bit", d8, w[i]);
         chk("early_cap_valid", if8.o_cap_valid, 0);
         @(negedge clk);
      end
      chk("cap_valid", if8.o_cap_valid, 1);
      chk("done_shift_en", se8, 0);
      chk("done_d", d8, 0);
      chk("done_load_ready", if8.o_load_ready, 0);
      chk("cap_data", if8.o_cap_data, exp_cap);
   endtask

   initial begin
      logic [7:0] words [4];
      logic [7:0] expq  [4];
      int n_acc, n_cap, cyc, last_acc;
      bit upd;

      rst = 1'b1;
      if8.i_load_valid = 1'b0; if8.i_load_data = '0; if8.i_cap_ready = 1'b0;
      if2.i_load_valid = 1'b0; if2.i_load_data = '0; if2.i_cap_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_load_ready", if8.o_load_ready, 1);
      chk("rst_shift_en", se8, 0);
      chk("rst_d", d8, 0);
      chk("rst_cap_valid", if8.o_cap_valid, 0);
      chk("rst_cap_data", if8.o_cap_data, 0);
      chk("rst_chain_q", q8, 0);
      chk("rst_w2_ready", if2.o_load_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // First exchange after reset reads back zero; then stall in DONE.
      exch8(8'hA5, 8'h00);
      for (int k = 0; k < 5; k++) begin
         if8.i_load_valid = (k % 2 == 0);
         if8.i_load_data  = 8'h77;
         @(negedge clk);
         chk("bp_cap_valid", if8.o_cap_valid, 1);
         chk("bp_cap_data", if8.o_cap_data, 8'h00);
         chk("bp_load_ready", if8.o_load_ready, 0);
         chk("bp_shift_en", se8, 0);
      end
      if8.i_load_valid = 1'b0;
      if8.i_cap_ready  = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", if8.o_cap_valid, 0);
      chk("bp_release_ready", if8.o_load_ready, 1);

      exch8(8'h3C, 8'hA5); @(negedge clk);
      exch8(8'hFF, 8'h3C); @(negedge clk);
      exch8(8'h00, 8'hFF); @(negedge clk);

      // Reset three shift cycles into an exchange.
      if8.i_load_valid = 1'b1;
      if8.i_load_data  = 8'hC3;
      @(negedge clk);
      if8.i_load_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_shift_en", se8, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ready", if8.o_load_ready, 1);
      chk("mid_rst_shift_en", se8, 0);
      chk("mid_rst_d", d8, 0);
      chk("mid_rst_cap_valid", if8.o_cap_valid, 0);
      chk("mid_rst_cap_data", if8.o_cap_data, 0);
      chk("mid_rst_chain_q", q8, 0);
      exch8(8'h5A, 8'h00); @(negedge clk);

      // Back-to-back with load valid held high.
      for (int k = 0; k < 4; k++) words[k] = 8'($urandom);
      expq[0] = 8'h5A; expq[1] = words[0]; expq[2] = words[1]; expq[3] = words[2];
      n_acc = 0; n_cap = 0; cyc = 0; last_acc = 0; upd = 1'b0;
      if8.i_load_valid = 1'b1;
      if8.i_load_data  = words[0];
      while (n_cap < 4 && cyc < 200) begin
         if (upd) begin
            upd = 1'b0;
            if (n_acc < 4) if8.i_load_data = words[n_acc];
            else           if8.i_load_valid = 1'b0;
         end
         if (if8.o_load_ready && if8.i_load_valid) begin
            if (n_acc > 0) chk("b2b_spacing", 64'(cyc - last_acc), 10);
            last_acc = cyc;
            n_acc++;
            upd = 1'b1;
         end
         if (if8.o_cap_valid) begin
            chk("b2b_cap_data", if8.o_cap_data, expq[n_cap]);
            n_cap++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("b2b_timeout", 64'(cyc < 200), 1);
      chk("b2b_accepts", 64'(n_acc), 4);
      if8.i_load_valid = 1'b0;
      @(negedge clk);

      // WIDTH=2 instance.
      chk("w2_idle_ready", if2.o_load_ready, 1);
      if2.i_load_valid = 1'b1;
      if2.i_load_data  = 2'b10;
      @(negedge clk);
      if2.i_load_valid = 1'b0;
      chk("w2_se_0", se2, 1);
      chk("w2_d_0", d2, 0);
      @(negedge clk);
      chk("w2_se_1", se2, 1);
      chk("w2_d_1", d2, 1);
      @(negedge clk);
      chk("w2_cap_valid_a", if2.o_cap_valid, 1);
      chk("w2_cap_data_a", if2.o_cap_data, 2'b00);
      @(negedge clk);
      chk("w2_ready_b", if2.o_load_ready, 1);
      if2.i_load_valid = 1'b1;
      if2.i_load_data  = 2'b01;
      @(negedge clk);
      if2.i_load_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("w2_cap_valid_b", if2.o_cap_valid, 1);
      chk("w2_cap_data_b", if2.o_cap_data, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dff_scan_ctrl.md
# dff_scan_ctrl

Sequencing controller for a serial scan chain of WIDTH single-bit D flip-flops. It accepts a parallel word over a valid/ready handshake and shifts that word into the chain LSB-first over WIDTH cycles. In the same cycles it captures the bits shifted out of the chain tail. The captured word is presented over a second valid/ready handshake. It sits between a configuration/test master and the flip-flop chain it owns, giving the master atomic parallel write-and-readback of the chain.

## Interface
- WIDTH, 8, chain length and data word width; legal range 2..64.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_load_valid  input  1  master presents a word to load.
- o_load_ready  output  1  controller can accept a word.
- i_load_data  input  WIDTH  word to shift into the chain.
- o_D  output  1  serial data to chain stage 0.
- o_shift_en  output  1  chain advances one stage on this edge.
- i_Q  input  1  output of chain tail (stage WIDTH-1).
- o_cap_valid  output  1  captured word is available.
- i_cap_ready  input  1  master accepts the captured word.
- o_cap_data  output  WIDTH  word shifted out of the chain.

## Operation
- States:
  - IDLE: o_load_ready=1.
  - SHIFT: serial exchange in progress.
  - DONE: o_cap_valid=1.
- IDLE→SHIFT on i_load_valid && o_load_ready.
  - Load i_load_data into the shift register.
  - Clear the bit counter to 0.
- SHIFT, every cycle:
  - o_shift_en=1 and o_D = shift register bit 0.
  - Shift register shifts right by one.
  - i_Q is sampled and shifted into o_cap_data at bit WIDTH-1; o_cap_data shifts right.
  - Counter increments.
- SHIFT→DONE on the edge where the counter equals WIDTH-1.
- DONE→IDLE on i_cap_ready. o_cap_data holds steady while o_cap_valid=1.
- o_shift_en=0 and o_D=0 in IDLE and DONE.
- i_load_valid is ignored outside IDLE.
- i_cap_ready is ignored outside DONE.
- Counter width is $clog2(WIDTH). The counter never exceeds WIDTH-1.
- The chain resets to all zeros. It holds its value whenever o_shift_en=0.
- Word ordering: the word captured in exchange n equals the word loaded in exchange n-1. The first exchange after reset captures 0.

## Timing
- Reset values:
  - State IDLE.
  - o_load_ready=1, o_shift_en=0, o_D=0, o_cap_valid=0, o_cap_data=0.
  - Shift register and counter 0.
- Load accepted at edge E0. o_shift_en is high for exactly WIDTH cycles, sampled at edges E1..EW.
- o_cap_valid rises after edge EW, i.e. WIDTH cycles after acceptance.
- i_Q is sampled pre-shift, i.e. the tail value before the same edge advances the chain.
- If i_cap_ready is already high when o_cap_valid rises, DONE lasts one cycle.
- o_load_ready returns the cycle after the DONE→IDLE edge. The minimum accept-to-accept period is WIDTH+2 cycles.
- o_load_ready and o_cap_valid are never high in the same cycle.
- i_rst asserted in any state, including mid-SHIFT:
  - Next cycle is IDLE with all outputs at reset values.
  - The partially shifted word is discarded and the chain returns to 0.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package dff_scan_pkg holds:
  - the state enum typedef scan_state_t {IDLE, SHIFT, DONE};
  - localparam MAX_WIDTH=64.
- The controller is a single module containing the FSM, counter, load shift register and capture shift register.
- Sub-module dff_chain:
  - Parameter WIDTH; ports i_clk, i_rst, i_shift_en, i_D, o_Q.
  - Built from single-bit synchronous-reset flip-flops.
  - Hold-mux feedback on each stage when i_shift_en=0.
  - Used by the bench and by the top level that pairs it with dff_scan_ctrl.

## Test plan
- Reset check: after reset, load 0xA5 → o_shift_en high 8 consecutive cycles; o_D sequence is 1,0,1,0,0,1,0,1; o_cap_valid after 8 cycles with o_cap_data=0x00.
- Readback: load 0x3C then 0xFF with i_cap_ready tied high → second capture is 0x3C; a third load of 0x00 captures 0xFF.
- Backpressure: hold i_cap_ready low 5 cycles in DONE → o_cap_valid and o_cap_data stable; i_load_valid pulses in that window are ignored; o_load_ready stays 0.
- Reset mid-exchange: assert i_rst after 3 shift cycles of 0xC3 → next cycle IDLE, all outputs at reset values; next exchange captures 0x00.
- Back-to-back: i_load_valid held high continuously with i_cap_ready=1 → accepts spaced exactly 10 cycles (WIDTH=8); no dropped or duplicated words across 4 random words.
- WIDTH=2 build: load 0b10 then 0b01 → o_D sequence 0,1; second capture 0b10.
